// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI slave.
package spi_slave_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    TRANSFER = 2'd2,
    DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a third delayed stage for rise/fall detection.
module spi_sync_edge
  import spi_slave_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  input  logic init,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [2:0] stage;

  always_ff @(posedge clk) begin
    if (reset) stage <= {3{init}};
    else       stage <= {stage[1:0], async_in};
  end

  assign sync = stage[1];
  assign rise = stage[1] & ~stage[2];
  assign fall = ~stage[1] & stage[2];

endmodule

// File: rtl/spi_slave.sv
// SPI slave supporting all four CPOL/CPHA modes, oversampled on the system clock.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              CS,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              busy,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned     CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t            current_state;
  logic [1:0]        cs_q;
  logic [1:0]        mosi_q;
  logic              cs_sync, mosi_sync;
  logic              sclk_sync, sclk_rise, sclk_fall;
  logic              sclk_edge, sclk_away;
  logic              leading, trailing, sample_edge, shift_edge;
  logic [DATA_W-1:0] tx_reg, rx_reg, rx_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [1:0]        settle;
  logic              armed;

  spi_sync_edge u_sclk_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (SCLK),
    .init     (CPOL),
    .sync     (sclk_sync),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q   <= 2'b11;
      mosi_q <= '0;
    end else begin
      cs_q   <= {cs_q[0], CS};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign cs_sync   = cs_q[1];
  assign mosi_sync = mosi_q[1];

  // An edge that leaves the SCLK level away from CPOL is a leading edge.
  assign sclk_edge   = sclk_rise | sclk_fall;
  assign sclk_away   = sclk_sync ^ CPOL;
  assign leading     = sclk_edge & sclk_away;
  assign trailing    = sclk_edge & ~sclk_away;
  assign sample_edge = CPHA ? trailing : leading;
  assign shift_edge  = CPHA ? leading : trailing;
  assign rx_next     = {rx_reg[DATA_W-2:0], mosi_sync};

  always_ff @(posedge clk) begin
    if (reset) begin
      current_state <= IDLE;
      busy          <= 1'b0;
      MISO          <= 1'b0;
      data_out      <= '0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      bit_cnt       <= '0;
      settle        <= '0;
      armed         <= 1'b0;
    end else begin
      // Only arm once CS has really been seen high after reset, not the sync reset value.
      if (settle != 2'd2) settle <= settle + 2'd1;
      if (settle == 2'd2 && cs_sync) armed <= 1'b1;

      case (current_state)
        IDLE: begin
          busy <= 1'b0;
          MISO <= 1'b0;
          if (!cs_sync && armed) begin
            current_state <= LOAD;
            busy          <= 1'b1;
          end
        end
        LOAD: begin
          if (cs_sync) begin
            current_state <= IDLE;
            busy          <= 1'b0;
            MISO          <= 1'b0;
          end else begin
            tx_reg        <= data_in;
            MISO          <= data_in[DATA_W-1];
            rx_reg        <= '0;
            bit_cnt       <= '0;
            current_state <= TRANSFER;
          end
        end
        TRANSFER: begin
          if (cs_sync) begin
            current_state <= IDLE;
            busy          <= 1'b0;
            MISO          <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_reg  <= rx_next;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST) begin
                data_out      <= rx_next;
                busy          <= 1'b0;
                current_state <= DONE;
              end
            end
            // With CPHA=1 the MSB is already on MISO, so the first leading edge is skipped.
            if (shift_edge && (!CPHA || bit_cnt != '0)) begin
              tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
              MISO   <= tx_reg[DATA_W-2];
            end
          end
        end
        DONE: begin
          busy <= 1'b0;
          if (cs_sync) current_state <= IDLE;
        end
        default: current_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: behavioural SPI master plus a per-cycle output model.
module tb_spi_slave;
  import spi_slave_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, CS, CPOL, CPHA, SCLK, MOSI, MISO, busy;
  logic [W-1:0] data_in, data_out;

  int unsigned  tests = 0;
  int unsigned  fails = 0;
  logic [W-1:0] exp_dout;
  bit           dout_window = 1'b0;
  bit           checking = 1'b0;
  int unsigned  cs_high_cnt = 0;
  int unsigned  busy_pulses = 0;
  logic         busy_q = 1'b0;

  spi_slave #(.DATA_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .CS       (CS),
    .CPOL     (CPOL),
    .CPHA     (CPHA),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .busy     (busy),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cs_high_cnt <= CS ? ((cs_high_cnt >= 100) ? 100 : cs_high_cnt + 1) : 0;
    busy_q      <= busy;
    if (busy === 1'b1 && busy_q === 1'b0) busy_pulses <= busy_pulses + 1;
  end

  // Model: data_out is the last completed word; with CS long high the slave is idle.
  always @(negedge clk) begin
    if (checking && !reset) begin
      if (!dout_window) check("data_out_model", 32'(data_out), 32'(exp_dout));
      if (cs_high_cnt >= 6) begin
        check("busy_idle", 32'(busy), 32'd0);
        check("miso_idle", 32'(MISO), 32'd0);
      end
    end
  end

  task automatic spi_frame(input logic cpol, input logic cpha,
                           input logic [W-1:0] m_word, input logic [W-1:0] s_word,
                           input int unsigned nbits, input int unsigned hp,
                           input bit raise_cs, output logic [W-1:0] captured);
    bit seen;
    captured = '0;
    seen = 1'b0;
    @(negedge clk);
    CPOL = cpol; CPHA = cpha; SCLK = cpol; data_in = s_word; MOSI = 1'b0;
    repeat (4) @(negedge clk);
    CS = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (busy === 1'b1);
    end
    check("busy_rise_4clk", 32'(seen), 32'd1);
    #(hp);
    for (int i = 0; i < int'(nbits); i++) begin
      if (nbits == W && i == W - 1) dout_window = 1'b1;
      if (!cpha) begin
        MOSI = m_word[W-1-i];
        #(hp); SCLK = ~cpol; captured = {captured[W-2:0], MISO};
        #(hp); SCLK = cpol;
      end else begin
        SCLK = ~cpol; MOSI = m_word[W-1-i];
        #(hp); SCLK = cpol; captured = {captured[W-2:0], MISO};
        #(hp);
      end
    end
    if (nbits == W) begin
      repeat (6) @(negedge clk);
      check("busy_low_before_cs", 32'(busy), 32'd0);
      exp_dout    = m_word;
      dout_window = 1'b0;
    end
    if (raise_cs) begin
      @(negedge clk);
      CS = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    logic [W-1:0] cap, mw, sw, mw2, sw2;
    logic [1:0]   md;
    int unsigned  p0;

    reset = 1'b1; CS = 1'b1; CPOL = 1'b0; CPHA = 1'b0; SCLK = 1'b0; MOSI = 1'b0;
    data_in = '0; exp_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_state", 32'(dut.current_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    checking = 1'b1;
    repeat (5) @(negedge clk);

    // Mode 0 at the slow SCLK rate, hand-computed words.
    spi_frame(1'b0, 1'b0, 8'h81, 8'h24, W, 500, 1'b1, cap);
    check("m0_captured", 32'(cap), 32'h24);
    check("m0_dout", 32'(data_out), 32'h81);

    for (int m = 1; m < 4; m++) begin
      md = 2'(m);
      mw = W'($urandom);
      sw = W'($urandom);
      spi_frame(md[1], md[0], mw, sw, W, 60, 1'b1, cap);
      check("mode_captured", 32'(cap), 32'(sw));
      check("mode_dout", 32'(data_out), 32'(mw));
    end

    // Abort after four bits: previous word must survive.
    spi_frame(1'b0, 1'b0, 8'h81, 8'h5A, W, 60, 1'b1, cap);
    check("pre_abort_dout", 32'(data_out), 32'h81);
    spi_frame(1'b0, 1'b0, 8'h3C, 8'hFF, 4, 60, 1'b1, cap);
    check("abort_state", 32'(dut.current_state), 32'(IDLE));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dout", 32'(data_out), 32'h81);

    // Two back-to-back frames with different modes.
    p0  = busy_pulses;
    mw  = 8'hC6; sw  = 8'h3B;
    mw2 = 8'h17; sw2 = 8'hE9;
    spi_frame(1'b0, 1'b1, mw, sw, W, 60, 1'b1, cap);
    check("pair1_captured", 32'(cap), 32'h3B);
    check("pair1_dout", 32'(data_out), 32'hC6);
    #380;
    spi_frame(1'b1, 1'b0, mw2, sw2, W, 60, 1'b1, cap);
    check("pair2_captured", 32'(cap), 32'hE9);
    check("pair2_dout", 32'(data_out), 32'h17);
    check("pair_busy_pulses", 32'(busy_pulses), 32'(p0 + 2));

    // SCLK activity with CS high must be ignored.
    p0 = busy_pulses;
    for (int i = 0; i < 20; i++) begin
      #60; SCLK = ~SCLK; MOSI = ~MOSI;
    end
    repeat (6) @(negedge clk);
    check("idle_sclk_dout", 32'(data_out), 32'h17);
    check("idle_sclk_pulses", 32'(busy_pulses), 32'(p0));

    // Reset during TRANSFER, then CS held low must not restart a frame.
    spi_frame(1'b0, 1'b0, 8'hA5, 8'hC3, 4, 60, 1'b0, cap);
    check("pre_reset_state", 32'(dut.current_state), 32'(TRANSFER));
    @(negedge clk);
    reset = 1'b1;
    exp_dout = '0;
    @(posedge clk); #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_miso", 32'(MISO), 32'd0);
    check("midrst_dout", 32'(data_out), 32'd0);
    check("midrst_state", 32'(dut.current_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    p0 = busy_pulses;
    repeat (20) @(negedge clk);
    check("rst_cs_low_busy", 32'(busy), 32'd0);
    check("rst_cs_low_pulses", 32'(busy_pulses), 32'(p0));
    CS = 1'b1;
    repeat (8) @(negedge clk);
    spi_frame(1'b1, 1'b1, 8'h6E, 8'h91, W, 60, 1'b1, cap);
    check("post_rst_captured", 32'(cap), 32'h91);
    check("post_rst_dout", 32'(data_out), 32'h6E);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
